// File: rtl/ahb_lite_sram_slave_pkg.sv
// Definitions: shared AHB-Lite bus widths, transfer/size/state types and response codes
package Definitions;
  localparam int DATAWIDTH = 32;
  localparam int ADDRWIDTH = 32;
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} Trans_t;
  typedef enum logic [2:0] {BYTE = 3'd0, HALF = 3'd1, WORD = 3'd2} Size_t;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} SlvState_t;
  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERROR = 1'b1;
endpackage

// File: rtl/ahb_byte_mem.sv
// ahb_byte_mem: MEM_DEPTH x 32 word memory with byte-enable write and write-forwarding read
// Ports: clk; we/waddr/wdata byte-lane write port; raddr/rdata combinational read port
module ahb_byte_mem #(
  parameter int MEM_DEPTH = 256,
  localparam int AW = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [MEM_DEPTH];
  for (genvar b = 0; b < 4; b++) begin : g_lane
    always_ff @(posedge clk)
      if (we[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
    // a lane written on the same edge the reader samples shows the new byte
    assign rdata[b*8 +: 8] = we[b] && waddr == raddr ? wdata[b*8 +: 8] : mem[raddr][b*8 +: 8];
  end
endmodule

// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave: AHB-Lite SRAM slave with byte lanes, wait states and two-cycle ERROR
// Ports: HCLK/HRESET clock and async active-high reset; HSEL..HWDATA AHB-Lite slave inputs;
//        HRDATA/HREADYOUT/HRESP response fields towards the slave-to-master mux
module ahb_lite_sram_slave
  import Definitions::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 HSEL,
  input  logic [ADDRWIDTH-1:0] HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [2:0]           HBURST,
  input  logic [3:0]           HPROT,
  input  logic                 HMASTLOCK,
  input  logic                 HREADY,
  input  logic [DATAWIDTH-1:0] HWDATA,
  output logic [DATAWIDTH-1:0] HRDATA,
  output logic                 HREADYOUT,
  output logic                 HRESP
);
  localparam int AW = $clog2(MEM_DEPTH);
  SlvState_t state, state_n;
  logic [3:0] cnt, we, lanes;
  logic [AW+1:0] a_addr;
  logic [2:0] a_size;
  logic a_write, pend, open, acc, ill, rd_nxt;
  logic [AW-1:0] raddr;
  logic [31:0] rword;
  logic unused;
  assign unused = ^{HBURST, HPROT, HMASTLOCK, HADDR[ADDRWIDTH-1:AW+2], HTRANS[0]};
  assign open = state == ST_IDLE || state == ST_ERR2;
  assign acc = open && HSEL && HREADY && HTRANS[1];
  assign ill = HSIZE > 3'd2 || (HSIZE == HALF && HADDR[0]) || (HSIZE == WORD && HADDR[1:0] != 2'd0);
  assign lanes = a_size == BYTE ? 4'b0001 << a_addr[1:0] : a_size == HALF ? (a_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  // pend marks the completing cycle of a legal transfer, which only ever happens in ST_IDLE
  assign we = pend && a_write ? lanes : 4'd0;
  // with no wait states the read index comes straight off the address phase
  assign raddr = state == ST_WAIT ? a_addr[AW+1:2] : HADDR[AW+1:2];
  assign rd_nxt = state == ST_WAIT ? cnt == 4'd1 && !a_write : acc && !ill && !HWRITE && WAIT_STATES == 0;
  assign state_n = state == ST_WAIT ? (cnt == 4'd1 ? ST_IDLE : ST_WAIT) :
                   state == ST_ERR1 ? ST_ERR2 :
                   !acc ? ST_IDLE : ill ? ST_ERR1 : WAIT_STATES == 0 ? ST_IDLE : ST_WAIT;
  assign HREADYOUT = state != ST_WAIT && state != ST_ERR1;
  assign HRESP = state == ST_ERR1 || state == ST_ERR2 ? RESP_ERROR : RESP_OKAY;
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      state <= ST_IDLE;
      cnt <= 4'd0;
      pend <= 1'b0;
      a_addr <= '0;
      a_write <= 1'b0;
      a_size <= 3'd0;
      HRDATA <= '0;
    end else begin
      state <= state_n;
      pend <= state == ST_WAIT ? cnt == 4'd1 : acc && !ill && WAIT_STATES == 0;
      cnt <= state == ST_WAIT ? cnt - 4'd1 : acc && !ill ? 4'(WAIT_STATES) : 4'd0;
      HRDATA <= rd_nxt ? rword : '0;
      if (acc) begin
        a_addr <= HADDR[AW+1:0];
        a_write <= HWRITE;
        a_size <= HSIZE;
      end
    end
  ahb_byte_mem #(.MEM_DEPTH(MEM_DEPTH)) u_mem (
    .clk(HCLK),
    .we(we),
    .waddr(a_addr[AW+1:2]),
    .wdata(HWDATA),
    .raddr(raddr),
    .rdata(rword)
  );
endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// tb_ahb_lite_sram_slave: randomized and directed check of three slaves (0, 2, 3 wait states) against a transfer-level model
module tb_ahb_lite_sram_slave;
  import Definitions::*;
  typedef struct {
    logic        sel;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [1:0]  trans;
    logic [31:0] wdata;
    logic        nordy;
  } xf_t;
  logic HCLK = 1'b0, HRESET = 1'b1;
  logic [2:0] hsel = 3'd0;
  logic [31:0] HADDR = '0, HWDATA = '0;
  logic [1:0] HTRANS = IDLE;
  logic HWRITE = 1'b0, HMASTLOCK = 1'b0, HREADY = 1'b1;
  logic [2:0] HSIZE = 3'd0, HBURST = 3'd0;
  logic [3:0] HPROT = 4'd3;
  logic [31:0] rdata [3];
  logic rdy [3], resp [3];
  logic [31:0] mm [3][256];
  xf_t q[$];
  int n_chk = 0, n_fail = 0;
  always #5 HCLK = ~HCLK;
  ahb_lite_sram_slave #(.WAIT_STATES(0)) u0 (.HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[0]), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
    .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(rdata[0]), .HREADYOUT(rdy[0]), .HRESP(resp[0]));
  ahb_lite_sram_slave #(.WAIT_STATES(2)) u1 (.HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[1]), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
    .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(rdata[1]), .HREADYOUT(rdy[1]), .HRESP(resp[1]));
  ahb_lite_sram_slave #(.WAIT_STATES(3)) u2 (.HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[2]), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
    .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(rdata[2]), .HREADYOUT(rdy[2]), .HRESP(resp[2]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask
  function automatic int ws(input int k);
    return k == 0 ? 0 : k == 1 ? 2 : 3;
  endfunction
  function automatic logic illegal(input xf_t x);
    return x.size > 3'd2 || (x.size == 3'd1 && x.addr[0]) || (x.size == 3'd2 && x.addr[1:0] != 2'd0);
  endfunction
  function automatic xf_t mk(input logic s, input logic [31:0] a, input logic w, input logic [2:0] sz,
                             input logic [1:0] t, input logic [31:0] d, input logic nr);
    xf_t x;
    x.sel = s; x.addr = a; x.wr = w; x.size = sz; x.trans = t; x.wdata = d; x.nordy = nr;
    return x;
  endfunction
  function automatic xf_t rnd();
    xf_t x;
    x.sel = $urandom_range(9) != 0;
    x.trans = $urandom_range(5) < 4 ? {1'b1, 1'($urandom)} : 2'($urandom);
    x.wr = 1'($urandom);
    x.size = $urandom_range(19) == 0 ? 3'($urandom_range(7, 3)) : 3'($urandom_range(2));
    x.addr = $urandom & 32'hFFFF_FC3F;
    if (x.size <= 3'd2 && $urandom_range(3) != 0) x.addr = (x.addr >> x.size) << x.size;
    x.wdata = $urandom;
    x.nordy = 1'b0;
    return x;
  endfunction
  // Plays the queue as a pipelined master on slave k; expects to start and ends at posedge+1
  task automatic run(input int k);
    xf_t dp, ap, idle;
    logic have = 1'b0, er, es;
    logic [31:0] ed;
    int cyc = 0, guard = 0, l;
    idle = mk(0, 0, 0, 0, IDLE, 0, 0);
    dp = idle;
    while ((q.size() != 0 || have) && guard < 20000) begin
      guard++;
      if (!have) begin er = 1; es = 0; ed = 0; end
      else if (illegal(dp)) begin er = cyc == 1; es = 1; ed = 0; end
      else begin
        er = cyc == ws(k);
        es = 0;
        ed = er && !dp.wr ? mm[k][dp.addr[9:2]] : 32'd0;
      end
      chk("hreadyout", {31'd0, rdy[k]}, {31'd0, er});
      chk("hresp", {31'd0, resp[k]}, {31'd0, es});
      chk("hrdata", rdata[k], ed);
      for (int j = 0; j < 3; j++)
        if (j != k) chk("unselected_quiet", {rdy[j], resp[j], rdata[j]}, {1'b1, 1'b0, 32'd0});
      HWDATA = have ? dp.wdata : $urandom;
      ap = q.size() != 0 ? q[0] : idle;
      hsel = ap.sel ? 3'(1 << k) : 3'd0;
      HADDR = ap.addr; HTRANS = ap.trans; HWRITE = ap.wr; HSIZE = ap.size;
      HREADY = er && !ap.nordy;
      if (er) begin
        if (have && dp.wr && !illegal(dp))
          for (int b = 0; b < (1 << dp.size); b++) begin
            l = int'(dp.addr[1:0]) + b;
            mm[k][dp.addr[9:2]][l*8 +: 8] = dp.wdata[l*8 +: 8];
          end
        have = HREADY && ap.sel && ap.trans[1];
        dp = ap;
        cyc = 0;
        if (q.size() != 0) void'(q.pop_front());
      end else cyc++;
      @(posedge HCLK); #1;
    end
    chk("run_finished", q.size(), 0);
    q.delete();
    hsel = 3'd0; HTRANS = IDLE; HREADY = 1'b1;
  endtask
  initial begin
    repeat (2) @(posedge HCLK);
    #1;
    for (int k = 0; k < 3; k++) chk("in_reset", {rdy[k], resp[k], rdata[k]}, {1'b1, 1'b0, 32'd0});
    HRESET = 1'b0;
    @(posedge HCLK); #1;
    for (int k = 0; k < 3; k++) chk("after_reset", {rdy[k], resp[k], rdata[k]}, {1'b1, 1'b0, 32'd0});
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 256; i++) q.push_back(mk(1, i * 4, 1, WORD, i == 0 ? NONSEQ : SEQ, $urandom, 0));
      run(k);
    end
    q.push_back(mk(1, 32'h10, 1, WORD, NONSEQ, 32'hDEADBEEF, 0));
    q.push_back(mk(1, 32'h10, 0, WORD, NONSEQ, 0, 0));
    q.push_back(mk(1, 32'h20, 1, WORD, NONSEQ, 32'h0000_0000, 0));
    q.push_back(mk(1, 32'h21, 1, BYTE, SEQ, 32'h1122_AA33, 0));
    q.push_back(mk(1, 32'h22, 1, HALF, SEQ, 32'h5566_7788, 0));
    q.push_back(mk(1, 32'h20, 0, WORD, SEQ, 0, 0));
    q.push_back(mk(1, 32'h13, 1, WORD, NONSEQ, 32'hBAD0_0001, 0));
    q.push_back(mk(1, 32'h10, 1, 3'd3, NONSEQ, 32'hBAD0_0002, 0));
    q.push_back(mk(1, 32'h10, 0, WORD, NONSEQ, 0, 0));
    for (int i = 0; i < 5; i++) q.push_back(mk(1, 32'h10, 1, WORD, BUSY, 32'h0BAD_0003, 0));
    for (int i = 0; i < 5; i++) q.push_back(mk(0, 32'h10, 1, WORD, NONSEQ, 32'h0BAD_0004, 0));
    q.push_back(mk(1, 32'h30, 1, WORD, NONSEQ, 32'h0BAD_0005, 1));
    q.push_back(mk(1, 32'h30, 1, WORD, NONSEQ, 32'h0BAD_0006, 1));
    q.push_back(mk(1, 32'h10, 0, WORD, NONSEQ, 0, 0));
    q.push_back(mk(1, 32'h30, 0, WORD, SEQ, 0, 0));
    run(0);
    q.push_back(mk(1, 32'h10, 0, WORD, NONSEQ, 0, 0));
    q.push_back(mk(1, 32'h14, 0, WORD, SEQ, 0, 0));
    q.push_back(mk(1, 32'h13, 0, WORD, NONSEQ, 0, 0));
    q.push_back(mk(1, 32'h11, 1, HALF, NONSEQ, 32'hBAD0_0007, 0));
    q.push_back(mk(1, 32'h10, 0, WORD, NONSEQ, 0, 0));
    run(2);
    hsel = 3'b010; HADDR = 32'h40; HTRANS = NONSEQ; HWRITE = 1'b1; HSIZE = WORD; HREADY = 1'b1;
    @(posedge HCLK); #1;
    chk("wait_before_reset", {rdy[1], resp[1]}, {1'b0, 1'b0});
    hsel = 3'd0; HTRANS = IDLE; HWDATA = 32'h1234_5678;
    HRESET = 1'b1;
    #1;
    chk("reset_mid_wait", {rdy[1], resp[1], rdata[1]}, {1'b1, 1'b0, 32'd0});
    repeat (3) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    q.push_back(mk(1, 32'h40, 0, WORD, NONSEQ, 0, 0));
    run(1);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 250; i++) q.push_back(rnd());
      run(k);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
AHB-Lite memory slave that sits directly downstream of the address decoder and upstream of the slave-to-master response mux. It is selected by one HSEL line (HSEL0 or HSEL1) and returns the three Slave_t fields (HRDATA, HRESP, HREADYOUT) to the mux. It holds a word-organised SRAM with byte-lane writes and a parameterised number of wait states. It issues the two-cycle ERROR response for illegal accesses.

Parameters:
MEM_DEPTH, 256, number of 32-bit words; the power of two sets the index width AW = log2(MEM_DEPTH)
WAIT_STATES, 0, HREADYOUT-low cycles inserted in every OKAY data phase (0..15)
DATAWIDTH, 32, data bus width, taken from package Definitions
ADDRWIDTH, 32, address bus width, taken from package Definitions

Ports:
HCLK  in  1  bus clock; all state on rising edge
HRESET  in  1  asynchronous, active-high reset
HSEL  in  1  slave select from decoder
HADDR  in  32  address-phase byte address; word index = HADDR[AW+1:2]
HTRANS  in  2  Trans_t: IDLE/BUSY/NONSEQ/SEQ
HWRITE  in  1  1 = write
HSIZE  in  3  0 = byte, 1 = half, 2 = word; others illegal
HBURST  in  3  accepted, not used
HPROT  in  4  accepted, not used
HMASTLOCK  in  1  accepted, not used
HREADY  in  1  bus-wide ready from mux output
HWDATA  in  32  write data, sampled in the final data-phase cycle
HRDATA  out  32  read data
HREADYOUT  out  1  slave ready
HRESP  out  1  0 = OKAY, 1 = ERROR

Behaviour:
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state=ST_IDLE, wait counter=0. Memory contents are not reset.
- Transfer acceptance: accepted at a rising edge when HSEL & HREADY & HTRANS[1] are all 1.
  - At that edge, HADDR[AW+1:0], HWRITE and HSIZE are captured.
  - IDLE and BUSY transfers, or HSEL=0, get a zero-wait OKAY: no state change.
- Legality:
  - HSIZE>2 is illegal.
  - A half access with HADDR[0]=1 is illegal.
  - A word access with HADDR[1:0]!=0 is illegal.
  - HADDR bits above AW+1 are ignored; the decoder owns range checking.
- FSM states: ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2.
  - ST_IDLE: HREADYOUT=1, HRESP=0.
    - Legal accept with WAIT_STATES=0: stay in ST_IDLE. The next cycle is the completing cycle.
    - Legal accept with WAIT_STATES>0: go to ST_WAIT, counter=WAIT_STATES.
    - Illegal accept: go to ST_ERR1.
  - ST_WAIT: HREADYOUT=0, HRESP=0, counter decrements each cycle. When counter reaches 1, the next cycle is the completing cycle with HREADYOUT=1.
  - ST_ERR1: HREADYOUT=0, HRESP=1; then go to ST_ERR2.
  - ST_ERR2: HREADYOUT=1, HRESP=1; acceptance of a new transfer is evaluated as in ST_IDLE.
- Data phase length: WAIT_STATES+1 cycles for OKAY, exactly 2 cycles for ERROR. Wait states are never added to ERROR.
- Pipelining: a new address phase may overlap the completing cycle of the previous transfer, so back-to-back NONSEQ/SEQ accesses sustain one transfer per WAIT_STATES+1 cycles.
- Write commit:
  - The write happens at the edge ending the completing cycle, using HWDATA sampled then.
  - Byte enables are little-endian, from captured HSIZE and HADDR[1:0]:
    - byte at offset n sets lane n only;
    - half at offset 0 sets lanes 0–1; half at offset 2 sets lanes 2–3;
    - word sets all four lanes.
  - ERROR transfers never write.
- Read data:
  - HRDATA is registered at the edge that begins the completing cycle, with the full word mem[index]. The master selects lanes.
  - HRDATA returns to 0 in every cycle that is not a read-completing cycle.
- Forwarding: if a write commits on the same edge that loads HRDATA for a read of the same word (WAIT_STATES=0 back-to-back), HRDATA shows the merged post-write word.
- HREADY low from another slave: no capture occurs, outputs hold ST_IDLE values.
- Reset mid-transfer: outputs return to reset values immediately, the pending write is discarded, and the FSM goes to ST_IDLE.

Decomposition:
- Add to package Definitions:
  - Size_t enum: BYTE=3'd0, HALF=3'd1, WORD=3'd2
  - SlvState_t enum: ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2
  - constants RESP_OKAY=1'b0, RESP_ERROR=1'b1
- Sub-module ahb_byte_mem: MEM_DEPTH x 32 array with 4-bit byte-enable write port and a read port with same-edge write forwarding.
- The FSM, legality check and lane decode stay in the top.

Test Plan:
- Reset: assert HRESET for 3 cycles mid-wait, with WAIT_STATES=2 -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately; a subsequent read of the interrupted write's address returns the old data.
- Word write/read, WAIT_STATES=0: write 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> HRDATA=0xDEADBEEF in the first read data cycle via forwarding.
- Byte lanes: word write 0x00000000 to 0x20, byte write 0xAA at 0x21, half write 0x5566 at 0x22 -> word read 0x20 returns 0x5566AA00.
- Wait states, WAIT_STATES=3: read 0x10 -> HREADYOUT low for exactly 3 cycles, then high with data; a SEQ address held during the waits is captured only on the ready cycle.
- Errors: word access at 0x13, then HSIZE=3 -> each gives HRESP=1/HREADYOUT=0 then HRESP=1/HREADYOUT=1; memory is unchanged; the following NONSEQ is accepted in ST_ERR2.
- Idle/unselected: HTRANS=BUSY or HSEL=0 for 10 cycles -> HREADYOUT=1, HRESP=0, no memory change.
